room_move_encoder: RTL and testbench
====================================

Name: room_move_encoder

Overview:
Front-end command source for the room FSM. It turns four raw pushbuttons into clean direction commands for the room FSM's n/s/e/w inputs. Each accepted press produces exactly one single-cycle, one-hot pulse; sampling, debouncing and multi-press rejection are handled here. It also counts accepted moves and locks out all commands once the room FSM reports win or death.

Parameters:
DB_CYCLES, 4, cycles a button vector must be stable to count as press or release (>=2)
CNT_W, 8, width of move counter
REPEAT_CYCLES, 16, auto-repeat period in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_n  input  1  raw north button, asynchronous, active-high
btn_s  input  1  raw south button
btn_e  input  1  raw east button
btn_w  input  1  raw west button
win  input  1  room FSM win status, synchronous to clk
d  input  1  room FSM dead status, synchronous to clk
n  output  1  north move pulse
s  output  1  south move pulse
e  output  1  east move pulse
w  output  1  west move pulse
reject  output  1  one-cycle pulse: stable press had more than one button
locked  output  1  high once game over
move_cnt  output  CNT_W  accepted moves, saturating

Behaviour:
- Reset (reset_n low, async): state IDLE; synchronizers, debounce counter and move_cnt cleared; all outputs 0.
- Each btn_* passes through a 2-flop synchronizer. The synchronized 4-bit vector is V = {n,s,e,w}.
- States: IDLE, DEBOUNCE, FIRE, HOLD, LOCKED.
- IDLE:
  - V != 0 -> DEBOUNCE.
  - Capture C = V.
  - Counter = 0.
- DEBOUNCE:
  - V != C -> IDLE, with the counter cleared (glitch discarded).
  - Otherwise the counter increments each cycle.
  - Counter == DB_CYCLES-1 with V == C: exactly one bit set -> FIRE; otherwise reject=1 for one cycle -> HOLD.
- FIRE:
  - Lasts one cycle.
  - The output matching C is high; all other outputs are low.
  - move_cnt increments, saturating at 2^CNT_W-1.
  - Next state HOLD.
- HOLD:
  - Waits for release.
  - Counter counts cycles with V == 0 and resets to 0 whenever V != 0.
  - Counter == DB_CYCLES-1 with V == 0 -> IDLE.
- Latency: raw button first high at edge 0 and held clean -> pulse high between edges DB_CYCLES+2 and DB_CYCLES+3.
- n/s/e/w are decoded only from FIRE: never more than one is high, and never high for more than one cycle.
- LOCKED:
  - win|d sampled high at any edge, in any state -> LOCKED, with priority over every other transition, including from FIRE (no pulse is issued in the following cycle).
  - locked=1.
  - n/s/e/w/reject held 0; move_cnt frozen.
  - Exits only via reset_n.
- Reset asserted mid-debounce or during FIRE: the pulse is aborted immediately (async) and no count is recorded.
- A button changing during HOLD never generates a move until a full release has been debounced.

Optional Feature:
ROOM_MOVE_AUTOREPEAT_EN
- Defined:
  - In HOLD, if V == C and C is one-hot, a repeat counter runs.
  - Every REPEAT_CYCLES cycles the block re-enters FIRE: another pulse, move_cnt increments, then back to HOLD with the repeat counter cleared.
  - Any change of V clears the repeat counter.
- Undefined: HOLD only waits for release; one pulse per press.

Test Plan:
- DB_CYCLES=4: btn_e held clean for 20 cycles, then released -> e high for exactly one cycle, between edges 6 and 7; move_cnt=1; no other outputs.
- btn_n bouncing 1-0-1 with 2-cycle periods, then stable for 10 cycles -> exactly one n pulse, after the stable window; move_cnt=1.
- btn_n and btn_w pressed together and held -> reject pulses once; no direction pulse; move_cnt unchanged.
- Three separate btn_s presses, each followed by a full release -> three s pulses; move_cnt=3. With CNT_W=2, five presses -> move_cnt stays at 3.
- d asserted while btn_w is in DEBOUNCE -> locked=1 next cycle; no w pulse; later presses ignored; reset_n low -> all outputs 0, locked=0.
- With ROOM_MOVE_AUTOREPEAT_EN and REPEAT_CYCLES=16: btn_e held 60 cycles after the first pulse -> first pulse, then a repeat pulse every 17 cycles (16 in HOLD + 1 in FIRE), i.e. 3 repeats.

Source files
------------

// File: rtl/room_move_encoder.sv
// Pushbutton front end for the room FSM: synchronize, debounce, reject chords, emit one-hot move pulses.
// Optional auto-repeat while a single button is held: define ROOM_MOVE_AUTOREPEAT_EN.
module room_move_encoder #(
  parameter int DB_CYCLES     = 4,
  parameter int CNT_W         = 8,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_n,
  input  logic             btn_s,
  input  logic             btn_e,
  input  logic             btn_w,
  input  logic             win,
  input  logic             d,
  output logic             n,
  output logic             s,
  output logic             e,
  output logic             w,
  output logic             reject,
  output logic             locked,
  output logic [CNT_W-1:0] move_cnt
);
  localparam int DCW = $clog2(DB_CYCLES);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, FIRE, HOLD, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       cap_q, cap_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
  logic [3:0]       dir_q, dir_d;
  logic             rej_q, rej_d;
  logic [3:0]       v;
  logic             cap_onehot;
`ifdef ROOM_MOVE_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_CYCLES);
  localparam logic [RCW-1:0] RPT_LAST = RCW'(REPEAT_CYCLES - 1);
  logic [RCW-1:0]   rpt_q, rpt_d;
`endif

  assign v          = sync2_q;
  assign cap_onehot = (cap_q != 4'd0) && ((cap_q & (cap_q - 4'd1)) == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_n, btn_s, btn_e, btn_w};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    move_cnt_d = move_cnt_q;
    dir_d      = '0;
    rej_d      = 1'b0;
`ifdef ROOM_MOVE_AUTOREPEAT_EN
    rpt_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (v != 4'd0) begin
          state_d = DEBOUNCE;
          cap_d   = v;
        end
      end
      DEBOUNCE: begin
        if (v != cap_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d = '0;
          if (cap_onehot) state_d = FIRE;
          else begin
            state_d = HOLD;
            rej_d   = 1'b1;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      FIRE: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        // Release counter only advances while every button reads released.
        if (v != 4'd0) cnt_d = '0;
        else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
`ifdef ROOM_MOVE_AUTOREPEAT_EN
        if (v == cap_q && cap_onehot) begin
          if (rpt_q == RPT_LAST) state_d = FIRE;
          else rpt_d = rpt_q + 1'b1;
        end
`endif
      end
      LOCKED: ;
      default: state_d = IDLE;
    endcase
    // Game over wins over every other transition, so a pending FIRE is dropped.
    if (win || d) begin
      state_d = LOCKED;
      rej_d   = 1'b0;
    end
    if (state_d == FIRE) begin
      dir_d = cap_q;
      if (move_cnt_q != {CNT_W{1'b1}}) move_cnt_d = move_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      cnt_q      <= '0;
      move_cnt_q <= '0;
      dir_q      <= '0;
      rej_q      <= 1'b0;
`ifdef ROOM_MOVE_AUTOREPEAT_EN
      rpt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      move_cnt_q <= move_cnt_d;
      dir_q      <= dir_d;
      rej_q      <= rej_d;
`ifdef ROOM_MOVE_AUTOREPEAT_EN
      rpt_q      <= rpt_d;
`endif
    end
  end

  assign {n, s, e, w} = dir_q;
  assign reject       = rej_q;
  assign locked       = (state_q == LOCKED);
  assign move_cnt     = move_cnt_q;
endmodule

// File: tb/tb_room_move_encoder.sv
// Directed bench for room_move_encoder: press/release vector table plus latency, bounce, lock and reset sequences.
module tb_room_move_encoder;
  logic clk = 1'b0;
  logic reset_n, btn_n, btn_s, btn_e, btn_w, win, d;
  logic n, s, e, w, reject, locked;
  logic [7:0] move_cnt;
  logic n2, s2, e2, w2, reject2, locked2;
  logic [1:0] move_cnt2;

  always #5 clk = ~clk;

  room_move_encoder #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .win(win), .d(d), .n(n), .s(s), .e(e), .w(w), .reject(reject), .locked(locked), .move_cnt(move_cnt));

  room_move_encoder #(.DB_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .win(win), .d(d), .n(n2), .s(s2), .e(e2), .w(w2), .reject(reject2), .locked(locked2), .move_cnt(move_cnt2));

  int checks = 0;
  int errors = 0;

  // Pulse monitor: cumulative counts, plus flags for multi-hot or stretched pulses.
  logic [3:0] dirv;
  logic [3:0] prev_dir = 4'd0;
  int pc[4] = '{0, 0, 0, 0};
  int rj = 0;
  int multi = 0;
  int wide = 0;
  assign dirv = {n, s, e, w};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) pc[i] <= pc[i] + int'(dirv[i]);
    if (reject) rj <= rj + 1;
    if ($countones(dirv) > 1) multi <= multi + 1;
    if (dirv != 4'd0 && prev_dir != 4'd0) wide <= wide + 1;
    prev_dir <= dirv;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_n, btn_s, btn_e, btn_w} = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_btn(4'd0);
    win = 1'b0;
    d   = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  function automatic int tot_pulses();
    return pc[0] + pc[1] + pc[2] + pc[3];
  endfunction

  typedef struct {
    logic [3:0] btn;
    int         press;
    int         exp_pulses;
    logic [3:0] exp_mask;
    int         exp_rej;
    int         exp_cnt8;
    int         exp_cnt2;
  } vec_t;

  vec_t vec[12];

  initial begin
    int base[4];
    int brj, bt, pulse_edge, np;
    logic [3:0] mask;

    // {n,s,e,w}; counts are cumulative from reset; CNT_W=2 instance saturates at 3
    vec[0]  = '{4'b0010, 20, 1, 4'b0010, 0, 1, 1};
    vec[1]  = '{4'b0100, 10, 1, 4'b0100, 0, 2, 2};
    vec[2]  = '{4'b0100, 10, 1, 4'b0100, 0, 3, 3};
    vec[3]  = '{4'b0100, 10, 1, 4'b0100, 0, 4, 3};
    vec[4]  = '{4'b1001, 20, 0, 4'b0000, 1, 4, 3};
    vec[5]  = '{4'b0001,  3, 0, 4'b0000, 0, 4, 3};
    vec[6]  = '{4'b0001,  4, 0, 4'b0000, 0, 4, 3};
    vec[7]  = '{4'b0001,  5, 1, 4'b0001, 0, 5, 3};
    vec[8]  = '{4'b0110,  8, 0, 4'b0000, 1, 5, 3};
    vec[9]  = '{4'b1111, 10, 0, 4'b0000, 1, 5, 3};
    vec[10] = '{4'b1000,  6, 1, 4'b1000, 0, 6, 3};
    vec[11] = '{4'b0100,  6, 1, 4'b0100, 0, 7, 3};

    reset_n = 1'b0;
    set_btn(4'd0);
    win = 1'b0;
    d   = 1'b0;
    tick(2);
    chk("reset_outputs", {n, s, e, w, reject, locked}, 0);
    chk("reset_move_cnt", move_cnt, 0);
    reset_n = 1'b1;
    tick(2);

    // Latency: east sampled high at edge 0, pulse only after edge 6
    set_btn(4'b0010);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("latency_edge%0d", k), {n, s, e, w, reject}, (k == 6) ? 5'b00100 : 5'b00000);
    end
    tick(10);
    set_btn(4'd0);
    tick(12);
    chk("latency_move_cnt", move_cnt, 1);

    // Bounce 1-0-1 in 2-cycle steps, then stable for 10
    pulse_edge = -1;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      btn_n = (k < 2) || (k >= 4 && k < 6) || (k >= 8 && k < 18);
      tick(1);
      if (n) begin
        np++;
        pulse_edge = k;
      end
    end
    tick(4);
    chk("bounce_pulses", np, 1);
    chk("bounce_pulse_edge", pulse_edge, 14);
    chk("bounce_move_cnt", move_cnt, 2);

    // Vector table
    do_reset();
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 4; i++) base[i] = pc[i];
      brj = rj;
      bt  = tot_pulses();
      set_btn(vec[v].btn);
      tick(vec[v].press);
      set_btn(4'd0);
      tick(12);
      for (int i = 0; i < 4; i++) mask[i] = (pc[i] - base[i]) > 0;
      chk($sformatf("vec%0d_pulses", v), tot_pulses() - bt, vec[v].exp_pulses);
      chk($sformatf("vec%0d_mask", v), mask, vec[v].exp_mask);
      chk($sformatf("vec%0d_reject", v), rj - brj, vec[v].exp_rej);
      chk($sformatf("vec%0d_cnt8", v), move_cnt, vec[v].exp_cnt8);
      chk($sformatf("vec%0d_cnt2", v), move_cnt2, vec[v].exp_cnt2);
    end

    // Death during west debounce locks; later presses ignored; reset clears
    do_reset();
    bt = tot_pulses();
    brj = rj;
    set_btn(4'b0001);
    tick(4);
    d = 1'b1;
    tick(1);
    chk("dead_locked", locked, 1);
    d = 1'b0;
    tick(10);
    set_btn(4'd0);
    tick(5);
    set_btn(4'b0010);
    tick(20);
    set_btn(4'd0);
    tick(8);
    chk("dead_no_pulses", tot_pulses() - bt, 0);
    chk("dead_no_reject", rj - brj, 0);
    chk("dead_move_cnt", move_cnt, 0);
    chk("dead_still_locked", locked, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("dead_reset_outputs", {n, s, e, w, reject, locked}, 0);
    chk("dead_reset_move_cnt", move_cnt, 0);

    // Win sampled on the edge that would enter FIRE: no pulse
    do_reset();
    bt = tot_pulses();
    set_btn(4'b0010);
    tick(6);
    win = 1'b1;
    tick(1);
    chk("win_fire_locked", locked, 1);
    chk("win_fire_e", e, 0);
    win = 1'b0;
    tick(3);
    set_btn(4'd0);
    chk("win_fire_no_pulses", tot_pulses() - bt, 0);
    chk("win_fire_move_cnt", move_cnt, 0);

    // Async reset during FIRE aborts the pulse and the count
    do_reset();
    set_btn(4'b0010);
    tick(7);
    chk("fire_e_high", e, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("fire_reset_e", e, 0);
    chk("fire_reset_move_cnt", move_cnt, 0);
    do_reset();

    chk("no_multi_hot", multi, 0);
    chk("no_wide_pulse", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
